ex_mem: RTL

Pipeline register between the EX stage and the combinational MEM stage of the 5-stage MIPS core. It latches EX results (GPR write-back and HI/LO write-back) once per cycle and honours the global stall vector and flush. It also carries the two-cycle MADD/MADDU/MSUB/MSUBU partial product and cycle count back to EX while EX is stalled. A saturating bubble counter is included for performance debug.

---
 rtl/ex_mem_pkg.sv | 43 ++++
 rtl/ex_mem_if.sv | 31 +++
 rtl/ex_mem_sat_counter.sv | 26 ++
 rtl/ex_mem.sv | 105 ++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared constants and helpers for the EX/MEM pipeline register.
// Holds the write-enable and reset encodings used by the core, the stall
// vector bit positions, and the per-edge action decode used by ex_mem.
package ex_mem_pkg;

    localparam logic       RstEnable    = 1'b1;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;
    localparam logic [4:0] NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;
    localparam int StallBus     = 6;
    localparam int StallEx      = 3;
    localparam int StallMem     = 4;

    // What the pipeline register does at a given rising edge.
    typedef enum logic [2:0] {
        STEP_RESET,
        STEP_FLUSH,
        STEP_BUBBLE,
        STEP_ADVANCE,
        STEP_HOLD
    } step_e;

    // Priority: reset, flush, then the EX/MEM stall pair. A MEM stall without
    // an EX stall cannot come from ctrl and falls through to advance.
    function automatic step_e decode_step(input logic rst,
                                          input logic flush,
                                          input logic stall_ex,
                                          input logic stall_mem);
        step_e s;
        if (rst == RstEnable)  s = STEP_RESET;
        else if (flush)        s = STEP_FLUSH;
        else if (!stall_ex)    s = STEP_ADVANCE;
        else if (!stall_mem)   s = STEP_BUBBLE;
        else                   s = STEP_HOLD;
        return s;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX-side results and their registered MEM-side copies.
// master: the EX stage (drives ex_*, observes mem_*).
// slave : the EX/MEM pipeline register (consumes ex_*, drives mem_*).
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ex_wd;
    logic              ex_wreg;
    logic [DATA_W-1:0] ex_wdata;
    logic [DATA_W-1:0] ex_hi;
    logic [DATA_W-1:0] ex_lo;
    logic              ex_whilo;

    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              mem_whilo;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo
    );
endinterface

// File: rtl/ex_mem_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), inc (count enable), count (value).
module sat_counter
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register of the 5-stage MIPS core.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   bus           ex_mem_if.slave: ex_* results in, mem_* registered out
//   hilo_i/cnt_i  MADD/MSUB partial product and cycle index from EX
//   stall, flush  stall vector and exception flush from ctrl
//   hilo_o/cnt_o  partial product / cycle index held for EX across a bubble
//   bubble_cnt    saturating count of bubbles inserted since reset
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int BCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    ex_mem_if.slave             bus,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o,
    output logic [BCNT_W-1:0]   bubble_cnt
);

    step_e step;

    logic [ADDR_W-1:0]   mem_wd_q;
    logic                mem_wreg_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   mem_hi_q;
    logic [DATA_W-1:0]   mem_lo_q;
    logic                mem_whilo_q;
    logic [2*DATA_W-1:0] hilo_q;
    logic [1:0]          cnt_q;

    // Only the EX and MEM stall bits matter here; the rest of the vector is
    // for other stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign step = decode_step(rst, flush, stall[StallEx], stall[StallMem]);

    always_ff @(posedge clk) begin
        case (step)
            STEP_RESET, STEP_FLUSH: begin
                mem_wd_q    <= ADDR_W'(NOPRegAddr);
                mem_wreg_q  <= WriteDisable;
                mem_wdata_q <= DATA_W'(ZeroWord);
                mem_hi_q    <= DATA_W'(ZeroWord);
                mem_lo_q    <= DATA_W'(ZeroWord);
                mem_whilo_q <= WriteDisable;
                hilo_q      <= '0;
                cnt_q       <= 2'b00;
            end
            STEP_BUBBLE: begin
                // MEM gets a NOP while EX keeps working on a multi-cycle
                // MADD/MSUB; its partial result is looped back through us.
                mem_wd_q    <= ADDR_W'(NOPRegAddr);
                mem_wreg_q  <= WriteDisable;
                mem_wdata_q <= DATA_W'(ZeroWord);
                mem_hi_q    <= DATA_W'(ZeroWord);
                mem_lo_q    <= DATA_W'(ZeroWord);
                mem_whilo_q <= WriteDisable;
                hilo_q      <= hilo_i;
                cnt_q       <= cnt_i;
            end
            STEP_ADVANCE: begin
                mem_wd_q    <= bus.ex_wd;
                mem_wreg_q  <= bus.ex_wreg;
                mem_wdata_q <= bus.ex_wdata;
                mem_hi_q    <= bus.ex_hi;
                mem_lo_q    <= bus.ex_lo;
                mem_whilo_q <= bus.ex_whilo;
                hilo_q      <= '0;
                cnt_q       <= 2'b00;
            end
            default: begin
                // STEP_HOLD: everything keeps its value.
            end
        endcase
    end

    sat_counter #(
        .WIDTH (BCNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (step == STEP_BUBBLE),
        .count (bubble_cnt)
    );

    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_wreg  = mem_wreg_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_hi    = mem_hi_q;
    assign bus.mem_lo    = mem_lo_q;
    assign bus.mem_whilo = mem_whilo_q;
    assign hilo_o        = hilo_q;
    assign cnt_o         = cnt_q;

endmodule
